// File: rtl/airi5c_div_unit_pkg.sv
// Shared op encodings and decode helpers for the RV32M divider.
package airi5c_div_unit_pkg;

  localparam int DIV_OP_WIDTH = 2;

  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REM  = 2'd2;
  localparam logic [DIV_OP_WIDTH-1:0] DIV_OP_REMU = 2'd3;

  // Encodings are chosen so bit 0 marks unsigned and bit 1 marks remainder.
  function automatic logic is_signed_op(input logic [DIV_OP_WIDTH-1:0] op);
    return !op[0];
  endfunction

  function automatic logic is_rem_op(input logic [DIV_OP_WIDTH-1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/airi5c_div_unit_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module airi5c_div_step #(
  parameter int XPR_LEN = 32
) (
  input  logic [XPR_LEN:0]   rem,
  input  logic               quo_msb,
  input  logic [XPR_LEN-1:0] div,
  output logic [XPR_LEN:0]   rem_next,
  output logic               quo_bit
);

  logic [XPR_LEN+1:0] shifted;
  logic [XPR_LEN+1:0] diff;

  always_comb begin
    shifted  = {rem, quo_msb};
    diff     = shifted - {2'b00, div};
    quo_bit  = !diff[XPR_LEN+1];
    rem_next = quo_bit ? diff[XPR_LEN:0] : shifted[XPR_LEN:0];
  end

endmodule

// File: rtl/airi5c_div_unit.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU; 34-cycle latency, 1 cycle for div-by-zero/overflow.
// Result holds in DONE until resp_ready_i; kill_i aborts from any state.
module airi5c_div_unit
  import airi5c_div_unit_pkg::*;
#(
  parameter int XPR_LEN = 32
) (
  input  logic                    clk_i,
  input  logic                    nreset_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [DIV_OP_WIDTH-1:0] op_i,
  input  logic [XPR_LEN-1:0]      src_a_i,
  input  logic [XPR_LEN-1:0]      src_b_i,
  input  logic                    kill_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [XPR_LEN-1:0]      resp_data_o
);

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_FIX  = 2'd2,
    DIV_ST_DONE = 2'd3
  } div_state_t;

  localparam int CNT_W = $clog2(XPR_LEN);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(XPR_LEN - 1);
  localparam logic [XPR_LEN-1:0] MIN_NEG  = {1'b1, {(XPR_LEN-1){1'b0}}};

  div_state_t                state;
  logic [DIV_OP_WIDTH-1:0]   op_q;
  logic                      neg_q;
  logic                      neg_r;
  logic [XPR_LEN:0]          rem;
  logic [XPR_LEN-1:0]        quo;
  logic [XPR_LEN-1:0]        div;
  logic [CNT_W-1:0]          cnt;

  logic                      a_neg, b_neg, div_zero, ovf;
  logic [XPR_LEN-1:0]        a_mag, b_mag, quo_fix, rem_fix;
  logic [XPR_LEN:0]          rem_next;
  logic                      quo_bit;

  always_comb begin
    a_neg    = is_signed_op(op_i) && src_a_i[XPR_LEN-1];
    b_neg    = is_signed_op(op_i) && src_b_i[XPR_LEN-1];
    a_mag    = a_neg ? -src_a_i : src_a_i;
    b_mag    = b_neg ? -src_b_i : src_b_i;
    div_zero = (src_b_i == '0);
    ovf      = is_signed_op(op_i) && (src_a_i == MIN_NEG) && (src_b_i == '1);
    quo_fix  = neg_q ? -quo : quo;
    rem_fix  = neg_r ? -rem[XPR_LEN-1:0] : rem[XPR_LEN-1:0];
  end

  airi5c_div_step #(.XPR_LEN(XPR_LEN)) u_step (
    .rem      (rem),
    .quo_msb  (quo[XPR_LEN-1]),
    .div      (div),
    .rem_next (rem_next),
    .quo_bit  (quo_bit)
  );

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state        <= DIV_ST_IDLE;
      op_q         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      rem          <= '0;
      quo          <= '0;
      div          <= '0;
      cnt          <= '0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
    end else if (kill_i) begin
      state        <= DIV_ST_IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
    end else begin
      case (state)
        DIV_ST_IDLE: begin
          if (req_valid_i) begin
            op_q        <= op_i;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            quo         <= a_mag;
            div         <= b_mag;
            rem         <= '0;
            cnt         <= CNT_LAST;
            req_ready_o <= 1'b0;
            if (div_zero) begin
              resp_data_o <= is_rem_op(op_i) ? src_a_i : '1;
              state       <= DIV_ST_DONE;
            end else if (ovf) begin
              resp_data_o <= is_rem_op(op_i) ? '0 : MIN_NEG;
              state       <= DIV_ST_DONE;
            end else begin
              state       <= DIV_ST_CALC;
            end
          end
        end
        DIV_ST_CALC: begin
          rem <= rem_next;
          quo <= {quo[XPR_LEN-2:0], quo_bit};
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= DIV_ST_FIX;
        end
        DIV_ST_FIX: begin
          resp_data_o <= is_rem_op(op_q) ? rem_fix : quo_fix;
          state       <= DIV_ST_DONE;
        end
        DIV_ST_DONE: begin
          // valid rises one edge after entering DONE; ready only retires a presented result
          if (resp_valid_o && resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state        <= DIV_ST_IDLE;
          end else begin
            resp_valid_o <= 1'b1;
          end
        end
        default: state <= DIV_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_airi5c_div_unit.sv
// Directed-vector bench with a response scoreboard for airi5c_div_unit.
module tb_airi5c_div_unit;
  import airi5c_div_unit_pkg::*;

  logic        clk_i = 1'b0;
  logic        nreset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        kill_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;

  always #5 clk_i = ~clk_i;

  airi5c_div_unit #(.XPR_LEN(32)) dut (
    .clk_i        (clk_i),
    .nreset_i     (nreset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .op_i         (op_i),
    .src_a_i      (src_a_i),
    .src_b_i      (src_b_i),
    .kill_i       (kill_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o)
  );

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: data checked every presented cycle, latency and pop on handshake.
  logic seen = 1'b0;
  int   first = 0;
  always @(negedge clk_i) begin
    if (nreset_i && resp_valid_o) begin
      if (!seen) begin
        seen  = 1'b1;
        first = cyc;
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got valid with data %h, expected none", resp_data_o);
      end else begin
        chk({sb[0].name, "_data"}, resp_data_o, sb[0].data);
        if (resp_ready_i) begin
          chk({sb[0].name, "_lat"}, 32'(first - sb[0].acc), 32'(sb[0].lat));
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_d, input int lat,
                       input bit push);
    exp_t e;
    bit   ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got req_ready_o=0, expected 1", name);
    end
    req_valid_i = 1'b1;
    op_i        = op;
    src_a_i     = a;
    src_b_i     = b;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    src_a_i     = $urandom;
    src_b_i     = $urandom;
    op_i        = 2'($urandom);
    if (push) begin
      e.data = exp_d;
      e.lat  = lat;
      e.acc  = cyc;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_i); #1;
      if (sb.size() == 0 && req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_d, input int lat);
    issue(name, op, a, b, exp_d, lat, 1'b1);
    wait_drain(name);
  endtask

  initial begin
    bit got_valid;
    nreset_i     = 1'b0;
    req_valid_i  = 1'b0;
    op_i         = DIV_OP_DIV;
    src_a_i      = '0;
    src_b_i      = '0;
    kill_i       = 1'b0;
    resp_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp_data", resp_data_o, 32'd0);
    nreset_i = 1'b1;
    @(posedge clk_i); #1;

    run("divu_100_7",   DIV_OP_DIVU, 32'd100,        32'd7,          32'd14,         34);
    run("remu_100_7",   DIV_OP_REMU, 32'd100,        32'd7,          32'd2,          34);
    run("div_m7_2",     DIV_OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   34);
    run("rem_m7_2",     DIV_OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34);
    run("div_7_m2",     DIV_OP_DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   34);
    run("rem_7_m2",     DIV_OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          34);
    run("div_by0",      DIV_OP_DIV,  32'h12345678,   32'd0,          32'hFFFFFFFF,   1);
    run("rem_by0",      DIV_OP_REM,  32'h12345678,   32'd0,          32'h12345678,   1);
    run("divu_by0",     DIV_OP_DIVU, 32'h80000001,   32'd0,          32'hFFFFFFFF,   1);
    run("div_ovf",      DIV_OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1);
    run("rem_ovf",      DIV_OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1);
    run("divu_noovf",   DIV_OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          34);
    run("remu_noovf",   DIV_OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   34);
    run("divu_max_1",   DIV_OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   34);

    // kill sampled at E11 during CALC
    issue("kill", DIV_OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (9) @(posedge clk_i);
    #1;
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    chk("kill_req_ready", 32'(req_ready_o), 32'd1);
    chk("kill_resp_valid", 32'(resp_valid_o), 32'd0);
    repeat (40) @(posedge clk_i);
    #1;
    run("divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 34);

    // backpressure: ready low for 5 cycles in DONE
    resp_ready_i = 1'b0;
    issue("bp", DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100, 34, 1'b1);
    got_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i); #1;
      if (resp_valid_o) begin
        got_valid = 1'b1;
        break;
      end
    end
    chk("bp_valid_seen", 32'(got_valid), 32'd1);
    repeat (5) begin
      chk("bp_valid_hold", 32'(resp_valid_o), 32'd1);
      chk("bp_req_ready", 32'(req_ready_o), 32'd0);
      @(posedge clk_i); #1;
    end
    resp_ready_i = 1'b1;
    wait_drain("bp");

    // async reset mid-operation
    issue("rst", DIV_OP_DIVU, 32'hFFFFFFFF, 32'd3, 32'd0, 0, 1'b0);
    repeat (19) @(posedge clk_i);
    #1;
    nreset_i = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready_o), 32'd1);
    chk("arst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("arst_resp_data", resp_data_o, 32'd0);
    @(posedge clk_i); #1;
    nreset_i = 1'b1;
    @(posedge clk_i); #1;
    run("post_rst", DIV_OP_DIVU, 32'd50, 32'd5, 32'd10, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
